regfile_wr_arbiter: RTL

- Sequencer and arbiter for the register file's single write port.
- After reset, and on request, it sweeps all registers to zero.
- It then shares the write port among NREQ writeback requesters using round-robin arbitration and a valid/ready handshake.
- It drives the register-file one-hot write-enable vector, write address and write data, all registered.

---
 rtl/regfile_wr_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/regfile_wr_arbiter.sv
// Write-port sequencer for the register file: zero-sweeps all registers after reset
// or on clear_req, then shares the single write port round-robin among NREQ requesters.
module regfile_wr_arbiter #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int NREQ     = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_req,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [NUM_REGS-1:0]      rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic                     clear_done,
  output logic                     busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NUM_REGS-1:0] WE_ONE  = {{(NUM_REGS-1){1'b0}}, 1'b1};
  localparam logic [NREQ-1:0]     RDY_ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   clr_cnt_r;
  logic [PTR_W-1:0]    rr_ptr_r;
  logic [PTR_W-1:0]    grant_idx_s;
  logic [PTR_W-1:0]    scan_idx_s;
  logic                grant_any_s;
  logic                xfer_s;
  logic                clr_last_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_data_s;

  assign clr_last_s = (clr_cnt_r == ADDR_W'(NUM_REGS - 1));
  assign clear_done = (state_r == ARB);
  assign busy       = (state_r == CLEAR) || (|rf_we);

  // Round-robin winner: scan downward so the requester closest to rr_ptr is kept last.
  always_comb begin
    grant_idx_s = '0;
    grant_any_s = 1'b0;
    scan_idx_s  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx_s = PTR_W'((int'(rr_ptr_r) + k) % NREQ);
      if (req_valid[scan_idx_s]) begin
        grant_idx_s = scan_idx_s;
        grant_any_s = 1'b1;
      end else begin
        grant_idx_s = grant_idx_s;
      end
    end
    sel_addr_s = req_addr[grant_idx_s*ADDR_W +: ADDR_W];
    sel_data_s = req_data[grant_idx_s*DATA_W +: DATA_W];
  end

  // Grant generation; clear_req and reset both suppress any grant.
  always_comb begin
    req_ready = '0;
    xfer_s    = 1'b0;
    if (rst_n && (state_r == ARB) && !clear_req && grant_any_s) begin
      req_ready = RDY_ONE << grant_idx_s;
      xfer_s    = 1'b1;
    end else begin
      req_ready = '0;
      xfer_s    = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      CLEAR: begin
        if (clr_last_s) state_nxt_s = ARB;
        else            state_nxt_s = CLEAR;
      end
      ARB: begin
        if (clear_req) state_nxt_s = CLEAR;
        else           state_nxt_s = ARB;
      end
      default: state_nxt_s = CLEAR;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= CLEAR;
    else        state_r <= state_nxt_s;
  end

  // Write-port registers, sweep counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we     <= '0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      clr_cnt_r <= '0;
      rr_ptr_r  <= '0;
    end else begin
      case (state_r)
        CLEAR: begin
          rf_we     <= WE_ONE << clr_cnt_r;
          rf_waddr  <= clr_cnt_r;
          rf_wdata  <= '0;
          clr_cnt_r <= clr_last_s ? '0 : clr_cnt_r + ADDR_W'(1);
        end
        ARB: begin
          clr_cnt_r <= '0;
          if (xfer_s) begin
            rf_we    <= WE_ONE << sel_addr_s;
            rf_waddr <= sel_addr_s;
            rf_wdata <= sel_data_s;
            rr_ptr_r <= (grant_idx_s == PTR_W'(NREQ - 1)) ? '0 : grant_idx_s + PTR_W'(1);
          end else begin
            rf_we    <= '0;
          end
        end
        default: begin
          rf_we     <= '0;
          clr_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule
